// File: rtl/shift_ex_stage.sv
// shift_ex_stage: two-register execute stage around the external 32-bit shifter.
// Adds arithmetic-right sign fill and a valid/ready writeback packet with flush.
module shift_ex_stage #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_op,
    input  logic          in_var,
    input  logic [AW-1:0] in_shamt,
    input  logic [DW-1:0] in_rs,
    input  logic [DW-1:0] in_rt,
    input  logic [RW-1:0] in_rd,
    output logic [DW-1:0] shf_data,
    output logic [AW-1:0] shf_amt,
    output logic          shf_direc,
    input  logic [DW-1:0] shf_result,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_result,
    output logic [RW-1:0] out_rd,
    output logic          out_we
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    logic          a_valid;
    logic [1:0]    a_op;
    logic [AW-1:0] a_amt;
    logic [DW-1:0] a_data;
    logic [RW-1:0] a_rd;

    logic          a_advance;
    logic          load;
    logic [DW-1:0] sra_fill;
    logic [DW-1:0] a_result;
    logic          a_we;
    logic          unused_rs;

    assign unused_rs = ^in_rs[DW-1:AW];

    assign a_advance = a_valid && (!out_valid || out_ready);
    assign in_ready  = !a_valid || a_advance;
    assign load      = in_valid && in_ready;

    assign shf_data  = a_data;
    assign shf_amt   = a_amt;
    assign shf_direc = (a_op != OP_SLL);

    // The shifter only does logical right shifts; SRA ORs in the vacated sign bits.
    assign sra_fill = a_data[DW-1] ? ~({DW{1'b1}} >> a_amt) : '0;

    always_comb begin
        a_result = '0;
        case (a_op)
            OP_SLL:  a_result = shf_result;
            OP_SRL:  a_result = shf_result;
            OP_SRA:  a_result = shf_result | sra_fill;
            default: a_result = '0;
        endcase
    end

    assign a_we = (a_op != OP_NOP) && (a_rd != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid    <= 1'b0;
            a_op       <= '0;
            a_amt      <= '0;
            a_data     <= '0;
            a_rd       <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_rd     <= '0;
            out_we     <= 1'b0;
        end else if (flush) begin
            a_valid   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (load) begin
                a_valid <= 1'b1;
                a_op    <= in_op;
                a_amt   <= in_var ? in_rs[AW-1:0] : in_shamt;
                a_data  <= in_rt;
                a_rd    <= in_rd;
            end else if (a_advance) begin
                a_valid <= 1'b0;
            end

            if (a_advance) begin
                out_valid  <= 1'b1;
                out_result <= a_result;
                out_rd     <= a_rd;
                out_we     <= a_we;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shift_ex_stage.sv
// tb_shift_ex_stage: directed table, stall/flush/reset sequences and random
// traffic checked against a queue-based arithmetic reference model.
module tb_shift_ex_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, in_var;
    logic [1:0]  in_op;
    logic [4:0]  in_shamt, in_rd, shf_amt, out_rd;
    logic [31:0] in_rs, in_rt, shf_data, shf_result, out_result;
    logic        shf_direc, out_valid, out_ready, out_we;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Team shifter: combinational, logical shifts only.
    assign shf_result = shf_direc ? (shf_data >> shf_amt) : (shf_data << shf_amt);

    shift_ex_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_var(in_var), .in_shamt(in_shamt),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .shf_data(shf_data), .shf_amt(shf_amt), .shf_direc(shf_direc),
        .shf_result(shf_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .out_we(out_we)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        we;
    } pkt_t;

    typedef struct {
        logic [1:0]  op;
        logic        vr;
        logic [4:0]  shamt;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        we;
    } vec_t;

    pkt_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic pkt_t model(input logic [1:0] op, input logic vr,
                                   input logic [4:0] shamt, input logic [31:0] rs,
                                   input logic [31:0] rt, input logic [4:0] rd);
        pkt_t p;
        int amt;
        amt = vr ? int'(rs % 32) : int'(shamt);
        case (op)
            2'd0:    p.res = rt << amt;
            2'd1:    p.res = rt >> amt;
            2'd2:    p.res = 32'($signed(rt) >>> amt);
            default: p.res = 32'd0;
        endcase
        p.rd = rd;
        p.we = (op != 2'd3) && (rd != 5'd0);
        return p;
    endfunction

    // One clock: observe handshakes before the edge, then step to edge+1.
    task automatic cycle();
        pkt_t e;
        #1;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", {31'd0, out_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("q_result", out_result, e.res);
                chk("q_rd", {27'd0, out_rd}, {27'd0, e.rd});
                chk("q_we", {31'd0, out_we}, {31'd0, e.we});
            end
        end
        if (rst || flush)
            exp_q.delete();
        else if (in_valid && in_ready)
            exp_q.push_back(model(in_op, in_var, in_shamt, in_rs, in_rt, in_rd));
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        in_valid = 1'b1;
        in_op    = v.op;
        in_var   = v.vr;
        in_shamt = v.shamt;
        in_rs    = v.rs;
        in_rt    = v.rt;
        in_rd    = v.rd;
    endtask

    vec_t tbl[11];
    vec_t sv[4];
    pkt_t sexp[4];
    logic [31:0] held;

    initial begin
        tbl[0]  = '{2'd0, 1'b0, 5'd4,  32'h0,        32'h0000_0001, 5'd3, 32'h0000_0010, 1'b1};
        tbl[1]  = '{2'd2, 1'b1, 5'd0,  32'h0000_0023, 32'h8000_0000, 5'd7, 32'hF000_0000, 1'b1};
        tbl[2]  = '{2'd1, 1'b1, 5'd0,  32'h0000_0023, 32'h8000_0000, 5'd7, 32'h1000_0000, 1'b1};
        tbl[3]  = '{2'd2, 1'b0, 5'd31, 32'h0,        32'h8000_0001, 5'd1, 32'hFFFF_FFFF, 1'b1};
        tbl[4]  = '{2'd0, 1'b0, 5'd0,  32'h0,        32'hDEAD_BEEF, 5'd2, 32'hDEAD_BEEF, 1'b1};
        tbl[5]  = '{2'd1, 1'b0, 5'd0,  32'h0,        32'hDEAD_BEEF, 5'd2, 32'hDEAD_BEEF, 1'b1};
        tbl[6]  = '{2'd2, 1'b1, 5'd9,  32'h0000_0020, 32'hDEAD_BEEF, 5'd2, 32'hDEAD_BEEF, 1'b1};
        tbl[7]  = '{2'd0, 1'b0, 5'd1,  32'h0,        32'h0000_0005, 5'd0, 32'h0000_000A, 1'b0};
        tbl[8]  = '{2'd3, 1'b0, 5'd2,  32'h0,        32'h0000_FFFF, 5'd5, 32'h0000_0000, 1'b0};
        tbl[9]  = '{2'd2, 1'b0, 5'd4,  32'h0,        32'h7000_0000, 5'd9, 32'h0700_0000, 1'b1};
        tbl[10] = '{2'd1, 1'b1, 5'd0,  32'hFFFF_FFE1, 32'h8000_0000, 5'd4, 32'h4000_0000, 1'b1};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = 2'd0; in_var = 1'b0; in_shamt = '0; in_rs = '0; in_rt = '0; in_rd = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
        chk("rst_out_we", {31'd0, out_we}, 32'd0);
        chk("rst_shf_data", shf_data, 32'd0);
        chk("rst_shf_amt", {27'd0, shf_amt}, 32'd0);
        chk("rst_shf_direc", {31'd0, shf_direc}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Single ops: visible exactly two edges after acceptance.
        foreach (tbl[i]) begin
            drive(tbl[i]);
            cycle();
            in_valid = 1'b0;
            cycle();
            chk($sformatf("t%0d_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("t%0d_result", i), out_result, tbl[i].res);
            chk($sformatf("t%0d_rd", i), {27'd0, out_rd}, {27'd0, tbl[i].rd});
            chk($sformatf("t%0d_we", i), {31'd0, out_we}, {31'd0, tbl[i].we});
            cycle();
            chk($sformatf("t%0d_drain", i), {31'd0, out_valid}, 32'd0);
        end

        // Back-to-back with a three-cycle downstream stall.
        for (int i = 0; i < 4; i++) begin
            sv[i] = '{2'(i % 3), 1'b0, 5'(i + 1), 32'h0, 32'h8000_00F0 + 32'(i),
                      5'(i + 10), 32'h0, 1'b0};
            sexp[i] = model(sv[i].op, 1'b0, sv[i].shamt, 32'h0, sv[i].rt, sv[i].rd);
        end
        begin
            int acc = 0;
            int got = 0;
            out_ready = 1'b0;
            for (int c = 0; c < 14; c++) begin
                out_ready = (c >= 5);
                if (acc < 4) drive(sv[acc]);
                else in_valid = 1'b0;
                #1;
                if (c == 2) chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
                if (c == 2) held = out_result;
                if (c == 3 || c == 4) begin
                    chk("stall_hold_result", out_result, held);
                    chk("stall_hold_rd", {27'd0, out_rd}, {27'd0, sexp[0].rd});
                    chk("stall_hold_valid", {31'd0, out_valid}, 32'd1);
                end
                if (out_valid && out_ready && got < 4) begin
                    chk($sformatf("stall_res%0d", got), out_result, sexp[got].res);
                    got++;
                end
                if (in_valid && in_ready) acc++;
                cycle();
            end
            chk("stall_accepted", 32'(acc), 32'd4);
            chk("stall_delivered", 32'(got), 32'd4);
            chk("stall_empty", 32'(exp_q.size()), 32'd0);
        end

        // Flush with ops in A and B plus an op presented.
        out_ready = 1'b0;
        drive(tbl[0]); cycle();
        drive(tbl[1]); cycle();
        drive(tbl[2]); flush = 1'b1; cycle();
        flush = 1'b0;
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_a_valid", {31'd0, dut.a_valid}, 32'd0);
        out_ready = 1'b1;
        drive(tbl[3]); cycle();
        in_valid = 1'b0; cycle();
        chk("post_flush_valid", {31'd0, out_valid}, 32'd1);
        chk("post_flush_result", out_result, 32'hFFFF_FFFF);
        cycle();

        // Reset while both stages hold a stalled op.
        out_ready = 1'b0;
        drive(tbl[4]); cycle();
        drive(tbl[9]); cycle();
        in_valid = 1'b0; cycle();
        rst = 1'b1; cycle();
        rst = 1'b0;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_out_result", out_result, 32'd0);
        chk("midrst_out_we", {31'd0, out_we}, 32'd0);
        chk("midrst_shf_amt", {27'd0, shf_amt}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("midrst_no_pkt", {31'd0, out_valid}, 32'd0);
        end

        // Random traffic against the queue model.
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            in_op     = 2'($urandom_range(0, 3));
            in_var    = 1'($urandom_range(0, 1));
            in_shamt  = 5'($urandom_range(0, 31));
            in_rs     = $urandom;
            in_rt     = $urandom;
            in_rd     = 5'($urandom_range(0, 31));
            cycle();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) cycle();
        chk("rand_drained", 32'(exp_q.size()), 32'd0);
        chk("rand_idle", {31'd0, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_ex_stage.md
Name: shift_ex_stage

Overview:
- Two-register execute-stage wrapper around the team's combinational 32-bit shifter (ports: data, 5-bit amount, direction with 0 = left, 1 = right).
- Accepts decoded shift instructions (SLL/SRL/SRA and variable forms) from decode over a valid/ready handshake.
- Drives the shifter from a registered operand stage and adds arithmetic-right sign fill.
- Delivers a registered writeback packet downstream with back-pressure and flush support.

Parameters:
- DW, 32, datapath width; fixed at 32 to match the shifter.
- AW, 5, shift-amount width (log2 DW).
- RW, 5, destination register index width.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- flush  input  1  synchronous kill of all in-flight ops
- in_valid  input  1  decode presents an op
- in_ready  output  1  stage can accept an op this cycle
- in_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 reserved (NOP)
- in_var  input  1  1 = amount from in_rs[4:0], 0 = amount from in_shamt
- in_shamt  input  5  immediate shift amount
- in_rs  input  32  variable-amount source register value
- in_rt  input  32  value to shift
- in_rd  input  5  destination register index
- shf_data  output  32  operand to shifter
- shf_amt  output  5  amount to shifter
- shf_direc  output  1  0 = left, 1 = right
- shf_result  input  32  shifter output (combinational from shf_*)
- out_valid  output  1  writeback packet valid
- out_ready  input  1  downstream accepts packet
- out_result  output  32  shift result
- out_rd  output  5  destination index
- out_we  output  1  register-write enable for this packet

Behaviour:
- Stage A register (a_valid, a_op, a_amt, a_data, a_rd): loads on in_valid && in_ready. a_amt = in_var ? in_rs[4:0] : in_shamt; a_data = in_rt.
- shf_data = a_data, shf_amt = a_amt, shf_direc = (a_op != 00). All three are driven purely from stage A registers.
- Stage A result:
  - SLL/SRL: shf_result.
  - SRA: shf_result | (a_data[31] ? ~(32'hFFFF_FFFF >> a_amt) : 0), built internally; the shifter is not modified.
  - op 11: result 0, we 0.
- Stage B register (out_valid, out_result, out_rd, out_we): loads from stage A when a_advance. out_we = (a_op != 11) && (a_rd != 0).
- Handshake:
  - a_advance = a_valid && (!out_valid || out_ready).
  - in_ready = !a_valid || a_advance (combinational; full throughput, one op per cycle).
  - out_valid clears when out_ready && !a_advance.
  - While out_valid && !out_ready, out_result/out_rd/out_we hold stable.
- Latency: accepted in cycle N, out_valid in cycle N+2 when unstalled. Throughput 1/cycle.
- Amount 0: result = a_data for all ops. Amount 31 SRA of a negative value gives 0xFFFF_FFFF.
- flush (cycle F):
  - a_valid and out_valid are 0 after edge F.
  - An op presented with in_valid in cycle F is dropped; in_ready is still driven per the rule above.
  - Data registers may retain stale values.
- Reset (priority over flush and everything else):
  - All valids 0; out_result 0, out_rd 0, out_we 0; stage A registers 0, so shf_data = 0, shf_amt = 0, shf_direc = 0.
  - in_ready = 1 the cycle after reset.
  - Reset mid-stall discards both ops with no output.
- Simultaneous load and drain of stage A in the same cycle is legal: new op replaces old as old moves to B.
- No combinational path from out_ready to out_* data. The in_ready dependency on out_ready is the only comb path.

Test Plan:
- Reset, then SLL in_rt=0x0000_0001, in_shamt=4, rd=3, out_ready=1 -> two cycles later out_valid=1, out_result=0x0000_0010, out_rd=3, out_we=1.
- SRA variable, in_rt=0x8000_0000, in_rs=0x0000_0023 (amt 3), rd=7 -> out_result=0xF000_0000; same with SRL -> 0x1000_0000; SRA amt 31 on 0x8000_0001 -> 0xFFFF_FFFF; any op amt 0 on 0xDEAD_BEEF -> 0xDEAD_BEEF.
- Back-to-back 4 ops with out_ready held 0 for 3 cycles -> in_ready drops after 2 accepted; out_* stable while stalled; on release all 4 appear in order, none lost or duplicated.
- rd=0 SLL, and op=11 with rd=5 -> out_valid=1, out_we=0 for both (result 0 for op 11).
- Flush asserted with ops in A and B plus in_valid=1 -> next cycle out_valid=0, a_valid=0, subsequent op emerges normally 2 cycles after acceptance.
- Assert rst during stall with both stages full -> after edge out_valid=0, out_result=0, out_we=0, shf_amt=0, in_ready=1; no packet emitted.
